mc_req_arbiter: RTL and testbench

//  Round-robin command arbiter between NUM_REQ requesters and the single DDR package command port.

---
 rtl/mc_req_arbiter.sv | 133 +++++++++++++
 tb/tb_mc_req_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_req_arbiter.sv
// Round-robin command arbiter for the DDR package command port, with per-bank backpressure
// and an in-order tag FIFO that routes returning read data back to the issuing requester.
module mc_req_arbiter #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BANK_LSB = 13,
  parameter int unsigned RD_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        power_on_rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_rw,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        pkg_valid,
  output logic                        pkg_rw,
  output logic [ADDR_W-1:0]           pkg_addr,
  output logic [DATA_W-1:0]           pkg_write_data,
  input  logic [3:0]                  ba_cmd_pm,
  input  logic [DATA_W-1:0]           read_data,
  input  logic                        read_data_valid,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [$clog2(RD_DEPTH):0]   rd_outstanding,
  output logic                        rsp_unexp_err
);
  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned PTR_W = $clog2(RD_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_pkg_valid;
  logic              r_pkg_rw;
  logic [ADDR_W-1:0] r_pkg_addr;
  logic [DATA_W-1:0] r_pkg_wdata;
  logic [ID_W-1:0]   r_tag_mem [RD_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_err;

  logic [NUM_REQ-1:0] w_elig;
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_scan_idx [NUM_REQ];
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_gnt_any;
  logic               w_not_full;
  logic               w_push;
  logic               w_pop;

  // Full check uses the registered count only; a same-cycle pop does not free a slot.
  assign w_not_full = r_count < CNT_W'(RD_DEPTH);

  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = req_valid[i] & ~ba_cmd_pm[req_addr[i*ADDR_W+BANK_LSB +: 2]] &
                  (req_rw[i] | w_not_full);
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_scan_idx[k] = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
    end
  end

  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_any && w_elig[w_scan_idx[k]]) begin
        w_gnt_any             = 1'b1;
        w_gnt_idx             = w_scan_idx[k];
        w_grant[w_scan_idx[k]] = 1'b1;
      end
    end
  end

  assign req_ready = w_grant & {NUM_REQ{power_on_rst_n}};
  assign w_push    = w_gnt_any & ~req_rw[w_gnt_idx];
  assign w_pop     = read_data_valid & (r_count != '0);

  always_ff @(posedge clk) begin
    if (!power_on_rst_n) begin
      r_rr_ptr    <= '0;
      r_pkg_valid <= 1'b0;
      r_pkg_rw    <= 1'b0;
      r_pkg_addr  <= '0;
      r_pkg_wdata <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_pkg_valid <= w_gnt_any;
      if (w_gnt_any) begin
        r_pkg_rw    <= req_rw[w_gnt_idx];
        r_pkg_addr  <= req_addr[w_gnt_idx*ADDR_W +: ADDR_W];
        r_pkg_wdata <= req_rw[w_gnt_idx] ? req_wdata[w_gnt_idx*DATA_W +: DATA_W] : '0;
        r_rr_ptr    <= ID_W'((int'(w_gnt_idx) + 1) % NUM_REQ);
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << r_tag_mem[r_rd_ptr]) : '0;
      if (w_pop) r_rsp_data <= read_data;
      if (read_data_valid && (r_count == '0)) r_err <= 1'b1;
    end
  end

  // Tag storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (power_on_rst_n && w_push) r_tag_mem[r_wr_ptr] <= w_gnt_idx;
  end

  assign pkg_valid      = r_pkg_valid;
  assign pkg_rw         = r_pkg_rw;
  assign pkg_addr       = r_pkg_addr;
  assign pkg_write_data = r_pkg_wdata;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rd_outstanding = r_count;
  assign rsp_unexp_err  = r_err;
endmodule

// File: tb/tb_mc_req_arbiter.sv
// Scoreboard bench for mc_req_arbiter: directed stimulus pushes expected commands and
// responses; a negedge monitor pops and compares whenever the DUT presents an output.
module tb_mc_req_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [1:0]   req_valid, req_rw, req_ready;
  logic [63:0]  req_addr;
  logic [127:0] req_wdata;
  logic         pkg_valid, pkg_rw;
  logic [31:0]  pkg_addr;
  logic [63:0]  pkg_write_data;
  logic [3:0]   ba_cmd_pm;
  logic [63:0]  read_data, rsp_data;
  logic         read_data_valid, rsp_unexp_err;
  logic [1:0]   rsp_valid;
  logic [3:0]   rd_outstanding;

  typedef struct { logic rw; logic [31:0] addr; logic [63:0] wd; } cmd_t;
  typedef struct { logic [1:0] oh; logic [63:0] d; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mc_req_arbiter #(.NUM_REQ(2), .ADDR_W(32), .DATA_W(64), .BANK_LSB(13), .RD_DEPTH(8)) dut (
    .clk(clk), .power_on_rst_n(rst_n), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .pkg_valid(pkg_valid), .pkg_rw(pkg_rw), .pkg_addr(pkg_addr),
    .pkg_write_data(pkg_write_data), .ba_cmd_pm(ba_cmd_pm), .read_data(read_data),
    .read_data_valid(read_data_valid), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rd_outstanding(rd_outstanding), .rsp_unexp_err(rsp_unexp_err)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Starts and ends at posedge+1; exp is the hand-computed grant for this cycle.
  task automatic grant_cycle(input logic [1:0] exp, input string nm);
    cmd_t c;
    int   idx;
    @(negedge clk);
    check(nm, 64'(req_ready), 64'(exp));
    if (exp != 2'b00) begin
      idx    = exp[1] ? 1 : 0;
      c.rw   = req_rw[idx];
      c.addr = req_addr[idx*32 +: 32];
      c.wd   = c.rw ? req_wdata[idx*64 +: 64] : 64'h0;
      cmd_q.push_back(c);
    end
    @(posedge clk); #1;
  endtask

  task automatic ret(input logic [63:0] d, input logic [1:0] oh);
    rsp_t r;
    read_data       = d;
    read_data_valid = 1'b1;
    if (oh != 2'b00) begin
      r.oh = oh;
      r.d  = d;
      rsp_q.push_back(r);
    end
    @(posedge clk); #1;
    read_data_valid = 1'b0;
    check("rsp_latency", 64'(rsp_valid), 64'(oh));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    cmd_t c;
    rsp_t r;
    forever begin
      @(negedge clk);
      if (pkg_valid === 1'b1) begin
        if (cmd_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_cmd actual=addr 0x%0h expected=none", pkg_addr);
        end else begin
          c = cmd_q.pop_front();
          check("cmd_rw", 64'(pkg_rw), 64'(c.rw));
          check("cmd_addr", 64'(pkg_addr), 64'(c.addr));
          check("cmd_wdata", pkg_write_data, c.wd);
        end
      end
      if (rsp_valid !== 2'b00) begin
        if (rsp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_rsp actual=0x%0h expected=none", rsp_valid);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_owner", 64'(rsp_valid), 64'(r.oh));
          check("rsp_data", rsp_data, r.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; req_rw = 2'b11; ba_cmd_pm = 4'h0;
    req_addr = {32'h0000_2000, 32'h0000_1000};
    req_wdata = {64'hB1B1_0000_0000_0002, 64'hA0A0_0000_0000_0001};
    read_data = '0; read_data_valid = 1'b0;

    repeat (3) begin
      @(posedge clk); #1;
      check("rst_ready", 64'(req_ready), 64'h0);
      check("rst_pkg_valid", 64'(pkg_valid), 64'h0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      check("rst_err", 64'(rsp_unexp_err), 64'h0);
    end
    check("rst_outstanding", 64'(rd_outstanding), 64'h0);
    rst_n = 1'b1;

    // Two writers alternate from rr_ptr=0
    grant_cycle(2'b01, "rr_g0");
    grant_cycle(2'b10, "rr_g1");
    grant_cycle(2'b01, "rr_g2");
    grant_cycle(2'b10, "rr_g3");
    req_valid = 2'b00;
    idle(2);

    // Bank 2 busy blocks req0 only
    req_addr = {32'h0000_0100, 32'h0000_4000};
    ba_cmd_pm = 4'b0100; req_valid = 2'b11;
    grant_cycle(2'b10, "bank_busy_req1");
    req_valid = 2'b01;
    grant_cycle(2'b00, "bank_busy_none");
    check("hold_valid", 64'(pkg_valid), 64'h0);
    check("hold_addr", 64'(pkg_addr), 64'h100);
    ba_cmd_pm = 4'b0000;
    grant_cycle(2'b01, "bank_free_req0");
    req_valid = 2'b00;
    idle(2);

    // Fill the tag FIFO with reads from req1
    req_valid = 2'b10; req_rw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      req_addr[63:32] = 32'(i * 64);
      grant_cycle(2'b10, "rd_fill");
    end
    grant_cycle(2'b00, "rd_full_block");
    check("rd_full_count", 64'(rd_outstanding), 64'h8);
    req_rw = 2'b10; req_addr[63:32] = 32'h0000_3000;
    grant_cycle(2'b10, "wr_when_full");
    req_valid = 2'b00;
    idle(1);
    for (int i = 0; i < 8; i++) ret(64'h100 + 64'(i), 2'b10);
    check("drain_count", 64'(rd_outstanding), 64'h0);

    // Interleaved reads, third grant coincides with the first return
    req_valid = 2'b11; req_rw = 2'b00;
    req_addr = {32'h0000_0020, 32'h0000_0000};
    grant_cycle(2'b01, "rd_req0");
    grant_cycle(2'b10, "rd_req1");
    req_valid = 2'b01;
    read_data = 64'hA; read_data_valid = 1'b1;
    r_push(2'b01, 64'hA);
    grant_cycle(2'b01, "rd_req0_b");
    read_data_valid = 1'b0; req_valid = 2'b00;
    check("rsp_a_latency", 64'(rsp_valid), 64'h1);
    check("push_pop_count", 64'(rd_outstanding), 64'h2);
    ret(64'hB, 2'b10);
    ret(64'hC, 2'b01);
    check("interleave_count", 64'(rd_outstanding), 64'h0);

    // Unexpected return
    idle(1);
    ret(64'hDEAD, 2'b00);
    check("unexp_err_set", 64'(rsp_unexp_err), 64'h1);
    idle(3);
    check("unexp_err_sticky", 64'(rsp_unexp_err), 64'h1);
    check("unexp_count", 64'(rd_outstanding), 64'h0);
    rst_n = 1'b0;
    idle(1);
    check("err_cleared", 64'(rsp_unexp_err), 64'h0);
    rst_n = 1'b1;

    idle(3);
    check("cmd_q_empty", 64'(cmd_q.size()), 64'h0);
    check("rsp_q_empty", 64'(rsp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  task automatic r_push(input logic [1:0] oh, input logic [63:0] d);
    rsp_t r;
    r.oh = oh;
    r.d  = d;
    rsp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
